// File: rtl/antirrebote_pkg.sv
// Project-wide constants and shared types for the slow-clock button debouncers.
// Defaults describe the parking counter board: 1 kHz clock, 20 ms debounce, pull-up buttons.
package antirrebote_pkg;

    localparam int CLK_SLOW_HZ        = 1000;
    localparam int DEBOUNCE_MS        = 20;
    localparam int STABLE_CNT_DEFAULT = CLK_SLOW_HZ * DEBOUNCE_MS / 1000;
    localparam int ACTIVE_LOW_DEFAULT = 1;

    // What a channel does on a given edge, decoded from sample/level/counter.
    typedef enum logic [1:0] {
        EV_HOLD   = 2'd0,
        EV_COUNT  = 2'd1,
        EV_COMMIT = 2'd2
    } canal_evt_e;

    // Raw pin value of a released button for the given polarity.
    function automatic logic inactive_raw(input int active_low);
        return (active_low != 0) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/antirrebote_canal.sv
// One debounced channel: 2-FF synchroniser, polarity normalisation, stability counter,
// registered level and one-cycle press/release pulses.
module antirrebote_canal
    import antirrebote_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEFAULT,
    parameter int ACTIVE_LOW = ACTIVE_LOW_DEFAULT
) (
    input  logic clk_slow,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam int               CNT_W    = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CNT - 1);
    localparam logic             IDLE_RAW = inactive_raw(ACTIVE_LOW);

    generate
        if (STABLE_CNT < 1) begin : g_bad_stable_cnt
            $error("antirrebote_canal: STABLE_CNT must be at least 1");
        end
    endgenerate

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             sample;
    canal_evt_e       evt;

    // Normalised so that 1 always means pressed, whatever the pin polarity.
    assign sample = sync2_q ^ IDLE_RAW;

    always_comb begin
        evt = EV_HOLD;
        if (sample != level_q) begin
            evt = (cnt_q == CNT_MAX) ? EV_COMMIT : EV_COUNT;
        end
    end

    // Any return of the sample to the current level restarts the count from zero.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (evt)
            EV_COUNT: begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            EV_COMMIT: begin
                level_d = sample;
                rise_d  = sample;
                fall_d  = ~sample;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_RAW;
            sync2_q <= IDLE_RAW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

endmodule

// File: rtl/antirrebote_multicanal.sv
// Multi-channel debouncer between the physical pins and the counter FSM.
// Pure wiring: one independent antirrebote_canal per input bit.
module antirrebote_multicanal
    import antirrebote_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = STABLE_CNT_DEFAULT,
    parameter int ACTIVE_LOW = ACTIVE_LOW_DEFAULT
) (
    input  logic            clk_slow,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall
);

    generate
        if (N_CH < 1) begin : g_bad_n_ch
            $error("antirrebote_multicanal: N_CH must be at least 1");
        end
        if (STABLE_CNT < 1) begin : g_bad_stable_cnt
            $error("antirrebote_multicanal: STABLE_CNT must be at least 1");
        end
    endgenerate

    generate
        for (genvar ch = 0; ch < N_CH; ch++) begin : g_canal
            antirrebote_canal #(
                .STABLE_CNT (STABLE_CNT),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_canal (
                .clk_slow  (clk_slow),
                .rst_n     (rst_n),
                .btn_in    (btn_in[ch]),
                .btn_level (btn_level[ch]),
                .btn_rise  (btn_rise[ch]),
                .btn_fall  (btn_fall[ch])
            );
        end
    endgenerate

endmodule
